element_wise_requant: RTL and testbench
=======================================

ELEMENT_WISE_REQUANT -- requirements
Module: element_wise_requant

Interface
REQ-001 Parameter INT32_WIDTH, default 32, width of the incoming fixed-point stream and of the quantization parameters.
REQ-002 Parameter INT8_WIDTH, default 8, width of the requantized output.
REQ-003 Parameter IDX_WIDTH, default 18, width of the element counters and of data_idx_o.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 start_i  input  1  one-cycle pulse; latches the configuration and begins a job.
REQ-007 num_elements_i  input  IDX_WIDTH  number of elements in the job; 0 SHALL be treated as 1.
REQ-008 output_multiplier_i  input  32 signed  Q31 quantized multiplier.
REQ-009 output_shift_i  input  32 signed  shift exponent; positive means left shift, negative means right shift.
REQ-010 output_zero_point_i  input  32 signed  output zero point.
REQ-011 act_min_i / act_max_i  input  8 signed each  activation clamp bounds.
REQ-012 data_in  input  32 signed  fixed-point element, e.g. an exp result.
REQ-013 valid_in  input  1  data_in is valid.
REQ-014 ready_o  output  1  block accepts data_in this cycle.
REQ-015 data_out  output  8 signed  requantized int8 element.
REQ-016 valid_out  output  1  data_out is valid.
REQ-017 ready_in  input  1  downstream accepts data_out.
REQ-018 data_idx_o  output  IDX_WIDTH  index of the element currently presented on data_out.
REQ-019 busy_o / done_o  output  1 each  job active / one-cycle pulse after the last element is transferred.

Function
REQ-020 FSM states: IDLE, RUN, DRAIN. Transitions:
- IDLE->RUN on start_i.
- RUN->DRAIN when the num_elements-th input is accepted.
- DRAIN->IDLE when the last output handshake completes; done_o pulses on that transition.
REQ-021 Configuration SHALL be registered on start_i and held constant until the job ends; start_i outside IDLE SHALL be ignored.
REQ-022 ready_o SHALL be 1 only in RUN, and only while the pipeline is not stalled.
REQ-023 An input transfer occurs when valid_in && ready_o; an output transfer occurs when valid_out && ready_in.
REQ-024 Pipeline: 3 stages, 3-cycle latency from input transfer to valid_out when there is no backpressure; throughput is 1 element per cycle.
REQ-025 Stage 1: x = data_in << max(shift,0), wrapping to 32 bits; then SaturatingRoundingDoublingHighMul(x, multiplier).
- If x == multiplier == INT32_MIN, the result SHALL be INT32_MAX.
- Otherwise: 64-bit product, plus nudge (2^30 if the product is >= 0, else 1-2^30), divided by 2^31 with truncation toward zero.
REQ-026 Stage 2: RoundingDivideByPOT by e = max(-shift,0), with e <= 31.
- mask = 2^e-1.
- threshold = (mask>>1) + (x<0).
- result = (x>>>e) + ((x & mask) > threshold).
REQ-027 Stage 3: add the zero point, clamp to [act_min, act_max], and output the low 8 bits.
REQ-028 Stall: when valid_out && !ready_in, all stages SHALL hold their contents; no data is lost or duplicated.
REQ-029 data_idx_o SHALL start at 0 for each job and increment on each output transfer.
REQ-030 If act_min > act_max, the output SHALL equal act_max.

Reset
REQ-031 On rst low, asynchronously:
- FSM goes to IDLE.
- All stage valids clear.
- valid_out=0, ready_o=0, busy_o=0, done_o=0, data_out=0, data_idx_o=0.
- The configuration registers clear to 0.
REQ-032 Reset mid-job SHALL discard all in-flight elements; after release, only a new start_i resumes operation.

Structure
REQ-033 INT32_MIN/INT32_MAX, the Q31 nudge constants and the FSM state encodings SHALL live in the shared params.vh.
REQ-034 SRDHM and RoundingDivideByPOT SHALL be functions in the shared function.vh, so the dequant path can reuse them.
REQ-035 One sub-module is natural: requant_stage, the 3-stage datapath with a common stall enable. Control and counters stay in the top module.

Verification
REQ-036 mult=2^30, shift=0, zp=0, bounds [-128,127], N=2, inputs 100 and 101 -> outputs 50 and 51 at idx 0 and 1, each 3 cycles after acceptance; done_o pulses once.
REQ-037 mult=2^30, shift=-1, zp=0, input 102 -> 26; input -100 with shift=0 -> -50.
REQ-038 mult=2^30, shift=0, zp=10, inputs 1000 and -1000 -> 127 and -128; with bounds [0,6], input 4 -> 6.
REQ-039 Backpressure: N=8 consecutive inputs, ready_in low for 4 cycles mid-stream -> ready_o drops, all 8 outputs arrive in order with idx 0..7, none lost or duplicated.
REQ-040 Assert rst mid-job with 2 elements in flight -> valid_out=0 immediately; a new job with N=1 then yields idx 0 and done_o.
REQ-041 mult=INT32_MIN, shift=0, input INT32_MIN, zp=0 -> SRDHM result INT32_MAX, output clamped to 127.

Source files
------------

// File: rtl/element_wise_requant_pkg.sv
// Shared constants, FSM encoding and fixed-point helper functions for the
// requantization datapath (also intended for reuse by the dequant path).
package element_wise_requant_pkg;

   localparam logic signed [31:0] INT32_MIN      = 32'sh8000_0000;
   localparam logic signed [31:0] INT32_MAX      = 32'sh7fff_ffff;
   // Rounding nudges applied to the 64-bit Q31 product before the divide.
   localparam logic signed [63:0] Q31_NUDGE_POS  = 64'sd1073741824;
   localparam logic signed [63:0] Q31_NUDGE_NEG  = -64'sd1073741823;
   // Bias that turns an arithmetic shift into truncation toward zero.
   localparam logic signed [63:0] Q31_TRUNC_BIAS = 64'sd2147483647;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Saturating rounding doubling high multiply of two Q31 values.
   function automatic logic signed [31:0] srdhm(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
      logic signed [63:0] a64;
      logic signed [63:0] b64;
      logic signed [63:0] ab;
      logic signed [63:0] nudged;
      logic signed [63:0] q;
      a64 = a;
      b64 = b;
      ab  = a64 * b64;
      if (ab >= 0) nudged = ab + Q31_NUDGE_POS;
      else         nudged = ab + Q31_NUDGE_NEG;
      if (nudged < 0) q = (nudged + Q31_TRUNC_BIAS) >>> 31;
      else            q = nudged >>> 31;
      if (a == INT32_MIN && b == INT32_MIN) return INT32_MAX;
      return $signed(q[31:0]);
   endfunction

   // Round-half-away-from-zero arithmetic right shift by e (0..31).
   function automatic logic signed [31:0] rdbpot(input logic signed [31:0] x,
                                                 input logic [4:0] e);
      logic [31:0]        mask;
      logic [31:0]        rem;
      logic [31:0]        thr;
      logic signed [31:0] q;
      mask = (32'd1 << e) - 32'd1;
      rem  = x & mask;
      thr  = (mask >> 1) + {31'd0, x[31]};
      q    = x >>> e;
      if (rem > thr) q = q + 32'sd1;
      return q;
   endfunction

endpackage

// File: rtl/element_wise_requant_stage.sv
// requant_stage: three-stage requantization datapath (SRDHM, rounding
// right shift, zero point + clamp). All stages advance on a common enable.
module requant_stage
   import element_wise_requant_pkg::*;
#(
   parameter int INT32_WIDTH = 32,
   parameter int INT8_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          in_valid,
   input  logic signed [INT32_WIDTH-1:0] data_in,
   input  logic signed [INT32_WIDTH-1:0] multiplier,
   input  logic signed [INT32_WIDTH-1:0] shift,
   input  logic signed [INT32_WIDTH-1:0] zero_point,
   input  logic signed [INT8_WIDTH-1:0]  act_min,
   input  logic signed [INT8_WIDTH-1:0]  act_max,
   output logic                          out_valid,
   output logic signed [INT8_WIDTH-1:0]  data_out
);

   logic                          s1_valid;
   logic signed [INT32_WIDTH-1:0] s1_data;
   logic                          s2_valid;
   logic signed [INT32_WIDTH-1:0] s2_data;

   logic [5:0]                    lsh;
   logic [4:0]                    rsh;
   logic signed [INT32_WIDTH-1:0] neg_shift;
   logic signed [INT32_WIDTH-1:0] x_shl;
   logic signed [INT32_WIDTH-1:0] s1_res;
   logic signed [INT32_WIDTH-1:0] s2_res;
   logic signed [INT32_WIDTH+1:0] sum;
   logic signed [INT32_WIDTH+1:0] lo;
   logic signed [INT32_WIDTH+1:0] hi;
   logic signed [INT32_WIDTH+1:0] clamped;

   // Split the signed exponent into a left amount (32 = everything shifted out) and a right amount capped at 31.
   always_comb begin
      lsh       = 6'd0;
      rsh       = 5'd0;
      neg_shift = -shift;
      if (shift > 32'sd31)      lsh = 6'd32;
      else if (shift > 32'sd0)  lsh = {1'b0, shift[4:0]};
      if (shift < -32'sd31)     rsh = 5'd31;
      else if (shift < 32'sd0)  rsh = neg_shift[4:0];
   end

   // Per-stage arithmetic: wrapping left shift + SRDHM, rounding divide, zero point and clamp.
   always_comb begin
      x_shl   = lsh[5] ? '0 : (data_in << lsh[4:0]);
      s1_res  = srdhm(x_shl, multiplier);
      s2_res  = rdbpot(s1_data, rsh);
      sum     = $signed({{2{s2_data[INT32_WIDTH-1]}}, s2_data})
              + $signed({{2{zero_point[INT32_WIDTH-1]}}, zero_point});
      lo      = $signed({{(INT32_WIDTH+2-INT8_WIDTH){act_min[INT8_WIDTH-1]}}, act_min});
      hi      = $signed({{(INT32_WIDTH+2-INT8_WIDTH){act_max[INT8_WIDTH-1]}}, act_max});
      clamped = sum;
      // Lower bound first, so an inverted range resolves to act_max.
      if (clamped < lo) clamped = lo;
      if (clamped > hi) clamped = hi;
   end

   // Pipeline registers; everything holds while en is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s2_valid  <= 1'b0;
         s2_data   <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
      end else if (en) begin
         s1_valid  <= in_valid;
         s1_data   <= s1_res;
         s2_valid  <= s1_valid;
         s2_data   <= s2_res;
         out_valid <= s2_valid;
         data_out  <= clamped[INT8_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/element_wise_requant.sv
// element_wise_requant: job control (FSM, configuration, counters) around
// the requant_stage datapath with ready/valid handshakes on both sides.
module element_wise_requant
   import element_wise_requant_pkg::*;
#(
   parameter int INT32_WIDTH = 32,
   parameter int INT8_WIDTH  = 8,
   parameter int IDX_WIDTH   = 18
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_i,
   input  logic [IDX_WIDTH-1:0]          num_elements_i,
   input  logic signed [INT32_WIDTH-1:0] output_multiplier_i,
   input  logic signed [INT32_WIDTH-1:0] output_shift_i,
   input  logic signed [INT32_WIDTH-1:0] output_zero_point_i,
   input  logic signed [INT8_WIDTH-1:0]  act_min_i,
   input  logic signed [INT8_WIDTH-1:0]  act_max_i,
   input  logic signed [INT32_WIDTH-1:0] data_in,
   input  logic                          valid_in,
   output logic                          ready_o,
   output logic signed [INT8_WIDTH-1:0]  data_out,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic [IDX_WIDTH-1:0]          data_idx_o,
   output logic                          busy_o,
   output logic                          done_o
);

   state_t                        state;
   state_t                        state_next;

   logic [IDX_WIDTH-1:0]          cfg_num;
   logic signed [INT32_WIDTH-1:0] cfg_mult;
   logic signed [INT32_WIDTH-1:0] cfg_shift;
   logic signed [INT32_WIDTH-1:0] cfg_zp;
   logic signed [INT8_WIDTH-1:0]  cfg_amin;
   logic signed [INT8_WIDTH-1:0]  cfg_amax;
   logic [IDX_WIDTH-1:0]          in_cnt;

   logic advance;
   logic in_fire;
   logic out_fire;
   logic job_start;
   logic last_in;
   logic last_out;

   assign advance   = !valid_out || ready_in;
   assign in_fire   = valid_in && ready_o;
   assign out_fire  = valid_out && ready_in;
   assign job_start = (state == ST_IDLE) && start_i;
   assign last_in   = in_fire && (in_cnt == cfg_num - IDX_WIDTH'(1));
   assign last_out  = out_fire && (data_idx_o == cfg_num - IDX_WIDTH'(1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start_i)  state_next = ST_RUN;
         ST_RUN:   if (last_in)  state_next = ST_DRAIN;
         ST_DRAIN: if (last_out) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; input acceptance stops whenever the pipe is stalled.
   always_comb begin
      ready_o = (state == ST_RUN) && advance;
      busy_o  = (state != ST_IDLE);
   end

   // Configuration is captured only when a job is launched from IDLE; a count of 0 runs one element.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_num   <= '0;
         cfg_mult  <= '0;
         cfg_shift <= '0;
         cfg_zp    <= '0;
         cfg_amin  <= '0;
         cfg_amax  <= '0;
      end else if (job_start) begin
         cfg_num   <= (num_elements_i == '0) ? IDX_WIDTH'(1) : num_elements_i;
         cfg_mult  <= output_multiplier_i;
         cfg_shift <= output_shift_i;
         cfg_zp    <= output_zero_point_i;
         cfg_amin  <= act_min_i;
         cfg_amax  <= act_max_i;
      end
   end

   // Accepted-input and output-index counters, cleared at each job launch; done pulses after the final output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_cnt     <= '0;
         data_idx_o <= '0;
         done_o     <= 1'b0;
      end else begin
         done_o <= (state == ST_DRAIN) && last_out;
         if (job_start) begin
            in_cnt     <= '0;
            data_idx_o <= '0;
         end else begin
            if (in_fire)  in_cnt     <= in_cnt + IDX_WIDTH'(1);
            if (out_fire) data_idx_o <= data_idx_o + IDX_WIDTH'(1);
         end
      end
   end

   requant_stage #(
      .INT32_WIDTH (INT32_WIDTH),
      .INT8_WIDTH  (INT8_WIDTH)
   ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (advance),
      .in_valid   (in_fire),
      .data_in    (data_in),
      .multiplier (cfg_mult),
      .shift      (cfg_shift),
      .zero_point (cfg_zp),
      .act_min    (cfg_amin),
      .act_max    (cfg_amax),
      .out_valid  (valid_out),
      .data_out   (data_out)
   );

endmodule

// File: tb/tb_element_wise_requant.sv
// Directed bench for element_wise_requant with hand-computed expectations.
module tb_element_wise_requant;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start_i = 1'b0;
   logic [17:0]        num_elements_i = '0;
   logic signed [31:0] output_multiplier_i = '0;
   logic signed [31:0] output_shift_i = '0;
   logic signed [31:0] output_zero_point_i = '0;
   logic signed [7:0]  act_min_i = '0;
   logic signed [7:0]  act_max_i = '0;
   logic signed [31:0] data_in = '0;
   logic               valid_in = 1'b0;
   logic               ready_o;
   logic signed [7:0]  data_out;
   logic               valid_out;
   logic               ready_in = 1'b1;
   logic [17:0]        data_idx_o;
   logic               busy_o;
   logic               done_o;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int acc_cyc [16];
   bit saw_drop;
   logic signed [31:0] in_vec  [16];
   logic signed [7:0]  exp_vec [16];

   localparam logic signed [31:0] M_HALF = 32'sd1073741824;
   localparam logic signed [31:0] I_MIN  = 32'sh8000_0000;

   element_wise_requant dut (
      .clk                 (clk),
      .rst                 (rst),
      .start_i             (start_i),
      .num_elements_i      (num_elements_i),
      .output_multiplier_i (output_multiplier_i),
      .output_shift_i      (output_shift_i),
      .output_zero_point_i (output_zero_point_i),
      .act_min_i           (act_min_i),
      .act_max_i           (act_max_i),
      .data_in             (data_in),
      .valid_in            (valid_in),
      .ready_o             (ready_o),
      .data_out            (data_out),
      .valid_out           (valid_out),
      .ready_in            (ready_in),
      .data_idx_o          (data_idx_o),
      .busy_o              (busy_o),
      .done_o              (done_o)
   );

   always #5 clk = ~clk;

   // Free-running cycle counter for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Count done pulses.
   always @(negedge clk) if (done_o) done_cnt <= done_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic do_job(input string name, input int n, input logic [17:0] num_cfg,
                         input logic signed [31:0] mult, input logic signed [31:0] shift,
                         input logic signed [31:0] zp, input logic signed [7:0] amin,
                         input logic signed [7:0] amax, input bit bp, input bit lat);
      int d0;
      int i;
      int got;
      int budget;
      bit injected;
      d0 = done_cnt;
      saw_drop = 0;
      injected = 0;
      @(posedge clk); #1;
      num_elements_i      = num_cfg;
      output_multiplier_i = mult;
      output_shift_i      = shift;
      output_zero_point_i = zp;
      act_min_i           = amin;
      act_max_i           = amax;
      start_i             = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      fork
         begin : driver
            i = 0;
            budget = 0;
            while (i < n && budget < 200) begin
               valid_in = 1'b1;
               data_in  = in_vec[i];
               @(negedge clk);
               if (ready_o) begin
                  acc_cyc[i] = cyc;
                  i++;
               end else saw_drop = 1;
               @(posedge clk); #1;
               budget++;
               start_i = 1'b0;
               // A start with a different configuration mid-job must be ignored.
               if (bp && i == 3 && !injected) begin
                  injected            = 1;
                  start_i             = 1'b1;
                  num_elements_i      = 18'd2;
                  output_multiplier_i = 32'sd0;
               end
            end
            valid_in = 1'b0;
            start_i  = 1'b0;
            if (i < n) check({name, "_in_timeout"}, i, n);
         end
         begin : monitor
            got = 0;
            budget = 0;
            while (got < n && budget < 300) begin
               @(negedge clk);
               budget++;
               if (valid_out && ready_in) begin
                  check($sformatf("%s_data%0d", name, got), data_out, exp_vec[got]);
                  check($sformatf("%s_idx%0d", name, got), data_idx_o, got);
                  if (lat) check($sformatf("%s_lat%0d", name, got), cyc - acc_cyc[got], 3);
                  got++;
               end
            end
            if (got < n) check({name, "_out_timeout"}, got, n);
         end
         begin : backpressure
            if (bp) begin
               repeat (4) @(posedge clk);
               #1 ready_in = 1'b0;
               repeat (4) @(posedge clk);
               #1 ready_in = 1'b1;
            end
         end
      join
      repeat (3) @(negedge clk);
      check({name, "_done"}, done_cnt - d0, 1);
      check({name, "_busy"}, busy_o, 0);
      check({name, "_nodup"}, valid_out, 0);
      if (bp) check({name, "_rdy_drop"}, saw_drop, 1);
      $display("job %s: %0d elements", name, n);
   endtask

   initial begin
      // Reset state while held in reset.
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_out", valid_out, 0);
      check("rst_ready_o", ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_data_out", data_out, 0);
      check("rst_idx", data_idx_o, 0);
      rst = 1'b1;

      in_vec[0] = 100;  in_vec[1] = 101;  exp_vec[0] = 50;  exp_vec[1] = 51;
      do_job("basic", 2, 18'd2, M_HALF, 0, 0, -128, 127, 0, 1);

      in_vec[0] = 102;  exp_vec[0] = 26;
      do_job("rshift1", 1, 18'd1, M_HALF, -1, 0, -128, 127, 0, 0);

      in_vec[0] = -100; exp_vec[0] = -50;
      do_job("neg", 1, 18'd1, M_HALF, 0, 0, -128, 127, 0, 0);

      in_vec[0] = -102; exp_vec[0] = -13;
      do_job("rshift2neg", 1, 18'd1, M_HALF, -2, 0, -128, 127, 0, 0);

      in_vec[0] = 25;   exp_vec[0] = 50;
      do_job("lshift2", 1, 18'd1, M_HALF, 2, 0, -128, 127, 0, 0);

      in_vec[0] = 1000; in_vec[1] = -1000; exp_vec[0] = 127; exp_vec[1] = -128;
      do_job("sat", 2, 18'd2, M_HALF, 0, 10, -128, 127, 0, 0);

      in_vec[0] = 4;    exp_vec[0] = 6;
      do_job("clamp", 1, 18'd1, M_HALF, 0, 10, 0, 6, 0, 0);

      in_vec[0] = 4;    exp_vec[0] = 5;
      do_job("inv_bounds", 1, 18'd1, M_HALF, 0, 10, 20, 5, 0, 0);

      in_vec[0] = I_MIN; exp_vec[0] = 127;
      do_job("int32min", 1, 18'd1, I_MIN, 0, 0, -128, 127, 0, 0);

      in_vec[0] = 100;  exp_vec[0] = 50;
      do_job("num_zero", 1, 18'd0, M_HALF, 0, 0, -128, 127, 0, 0);

      for (int k = 0; k < 8; k++) begin
         in_vec[k]  = 32'(10 * (k + 1));
         exp_vec[k] = 8'(5 * (k + 1));
      end
      do_job("bp", 8, 18'd8, M_HALF, 0, 0, -128, 127, 1, 0);

      // Reset mid-job with elements in flight.
      @(posedge clk); #1;
      num_elements_i      = 18'd4;
      output_multiplier_i = M_HALF;
      output_shift_i      = 0;
      output_zero_point_i = 0;
      act_min_i           = -128;
      act_max_i           = 127;
      start_i             = 1'b1;
      @(posedge clk); #1;
      start_i  = 1'b0;
      valid_in = 1'b1;
      data_in  = 100;
      @(posedge clk); #1;
      data_in  = 101;
      @(posedge clk); #1;
      valid_in = 1'b0;
      ready_in = 1'b0;
      @(posedge clk); #1;
      check("mid_valid_before", valid_out, 1);
      check("mid_data_before", data_out, 50);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_valid_out", valid_out, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_ready_o", ready_o, 0);
      check("mid_rst_data_out", data_out, 0);
      @(posedge clk); #1;
      rst      = 1'b1;
      ready_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_idle_valid", valid_out, 0);
      check("post_rst_idle_busy", busy_o, 0);
      $display("job mid_reset: 2 elements discarded");

      in_vec[0] = 100;  exp_vec[0] = 50;
      do_job("after_rst", 1, 18'd1, M_HALF, 0, 0, -128, 127, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
